// File: rtl/npi_ict_rd_arb.sv
// Round-robin read arbiter feeding an NPI address port and a read-status FIFO.
// One request is in flight at a time: IDLE grants, REQ holds the address request, DONE reports.
module npi_ict_rd_arb #(
  parameter int unsigned C_NUM_PORTS      = 4,
  parameter int unsigned C_PIM_ADDR_WIDTH = 32
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic [C_NUM_PORTS-1:0]                 req_valid,
  input  logic [C_NUM_PORTS*C_PIM_ADDR_WIDTH-1:0] req_addr,
  input  logic [C_NUM_PORTS*6-1:0]               req_len,
  output logic [C_NUM_PORTS-1:0]                 req_ack,
  output logic                                   req_err,
  output logic                                   PIM_AddrReq,
  input  logic                                   PIM_AddrAck,
  output logic [C_PIM_ADDR_WIDTH-1:0]            PIM_Addr,
  output logic                                   PIM_RNW,
  output logic [3:0]                             PIM_Size,
  output logic                                   PIM_RdModWr,
  output logic                                   rdsts_wren,
  output logic [5:0]                             rdsts_len,
  output logic [2:0]                             rdsts_nr,
  input  logic                                   rdsts_afull,
  output logic                                   busy
);

  localparam int unsigned IDX_W = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;
  localparam int unsigned AW    = C_PIM_ADDR_WIDTH;
  localparam int unsigned LEN_W = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q,    state_d;
  logic [IDX_W-1:0]       last_q,     last_d;
  logic [IDX_W-1:0]       gnt_q,      gnt_d;
  logic [AW-1:0]          addr_q,     addr_d;
  logic [3:0]             size_q,     size_d;
  logic [LEN_W-1:0]       len_q,      len_d;
  logic                   addr_req_q, addr_req_d;
  logic [C_NUM_PORTS-1:0] ack_q,      ack_d;
  logic                   err_q,      err_d;
  logic                   wren_q,     wren_d;
  logic [LEN_W-1:0]       rlen_q,     rlen_d;
  logic [2:0]             rnr_q,      rnr_d;
  logic                   busy_q,     busy_d;

  logic [IDX_W-1:0] cand_c;
  logic [IDX_W-1:0] sel_c;
  logic             sel_found_c;
  logic [AW-1:0]    sel_addr_c;
  logic [LEN_W-1:0] sel_len_c;
  logic [4:0]       sz_c;

  // {legal, size code}; anything outside the supported burst set is illegal
  function automatic logic [4:0] size_code(input logic [LEN_W-1:0] len);
    case (len)
      6'd1:    return 5'b1_0000;
      6'd4:    return 5'b1_0001;
      6'd8:    return 5'b1_0010;
      6'd16:   return 5'b1_0011;
      6'd32:   return 5'b1_0100;
      default: return 5'b0_0000;
    endcase
  endfunction

  // Round-robin pick: first requester after the last grant, wrapping
  always_comb begin
    cand_c      = '0;
    sel_c       = '0;
    sel_found_c = 1'b0;
    for (int unsigned i = 1; i <= C_NUM_PORTS; i++) begin
      cand_c = IDX_W'((32'(last_q) + i) % C_NUM_PORTS);
      if (!sel_found_c && req_valid[cand_c]) begin
        sel_found_c = 1'b1;
        sel_c       = cand_c;
      end
    end
  end

  always_comb begin
    sel_addr_c = '0;
    sel_len_c  = '0;
    for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
      if (IDX_W'(p) == sel_c) begin
        sel_addr_c = req_addr[p*AW +: AW];
        sel_len_c  = req_len[p*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    len_d      = len_q;
    addr_req_d = addr_req_q;
    ack_d      = '0;
    err_d      = 1'b0;
    wren_d     = 1'b0;
    rlen_d     = rlen_q;
    rnr_d      = rnr_q;
    sz_c       = size_code(sel_len_c);
    case (state_q)
      S_IDLE: begin
        if (sel_found_c && !rdsts_afull) begin
          last_d = sel_c;
          gnt_d  = sel_c;
          len_d  = sel_len_c;
          if (sz_c[4]) begin
            addr_d     = sel_addr_c;
            size_d     = sz_c[3:0];
            addr_req_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            // Rejected burst: acknowledge with error, never touch NPI or the status FIFO
            ack_d   = C_NUM_PORTS'(1) << sel_c;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (PIM_AddrAck) begin
          addr_req_d = 1'b0;
          wren_d     = 1'b1;
          rlen_d     = len_q;
          rnr_d      = 3'(gnt_q);
          ack_d      = C_NUM_PORTS'(1) << gnt_q;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(C_NUM_PORTS - 1);
      gnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      len_q      <= '0;
      addr_req_q <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      wren_q     <= 1'b0;
      rlen_q     <= '0;
      rnr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      len_q      <= len_d;
      addr_req_q <= addr_req_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      wren_q     <= wren_d;
      rlen_q     <= rlen_d;
      rnr_q      <= rnr_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_err     = err_q;
  assign PIM_AddrReq = addr_req_q;
  assign PIM_Addr    = addr_q;
  assign PIM_Size    = size_q;
  assign PIM_RNW     = 1'b1;
  assign PIM_RdModWr = 1'b0;
  assign rdsts_wren  = wren_q;
  assign rdsts_len   = rlen_q;
  assign rdsts_nr    = rnr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_npi_ict_rd_arb.sv
// Bench for npi_ict_rd_arb: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin by port order, size from log2 of the burst).
module tb_npi_ict_rd_arb;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            Clk;
  logic            Rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*6-1:0]  req_len;
  logic [N-1:0]    req_ack;
  logic            req_err;
  logic            PIM_AddrReq;
  logic            PIM_AddrAck;
  logic [AW-1:0]   PIM_Addr;
  logic            PIM_RNW;
  logic [3:0]      PIM_Size;
  logic            PIM_RdModWr;
  logic            rdsts_wren;
  logic [5:0]      rdsts_len;
  logic [2:0]      rdsts_nr;
  logic            rdsts_afull;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int model_last;
  logic [31:0] port_addr [N];
  int          port_len  [N];

  npi_ict_rd_arb #(.C_NUM_PORTS(N), .C_PIM_ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ack(req_ack), .req_err(req_err),
    .PIM_AddrReq(PIM_AddrReq), .PIM_AddrAck(PIM_AddrAck), .PIM_Addr(PIM_Addr),
    .PIM_RNW(PIM_RNW), .PIM_Size(PIM_Size), .PIM_RdModWr(PIM_RdModWr),
    .rdsts_wren(rdsts_wren), .rdsts_len(rdsts_len), .rdsts_nr(rdsts_nr),
    .rdsts_afull(rdsts_afull), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Lowest requester numbered above the last grant, otherwise the lowest requester overall
  function automatic int rr_pick(int last, logic [N-1:0] mask);
    for (int p = last + 1; p < N; p++) if (((32'(mask) >> p) & 32'd1) != 0) return p;
    for (int p = 0; p < N; p++) if (((32'(mask) >> p) & 32'd1) != 0) return p;
    return -1;
  endfunction

  function automatic int exp_size(int len);
    if (len == 1) return 0;
    if (len == 4 || len == 8 || len == 16 || len == 32) return $clog2(len) - 1;
    return -1;
  endfunction

  task automatic set_port(int p, logic [31:0] a, int l);
    port_addr[p] = a;
    port_len[p]  = l;
    req_addr[p*AW +: AW] = a;
    req_len[p*6 +: 6]    = 6'(l);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    req_valid = '0;
    PIM_AddrAck = 1'b0;
    rdsts_afull = 1'b0;
    step();
    step();
    Rst = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    req_valid = '0; req_addr = '0; req_len = '0;
    PIM_AddrAck = 1'b0; rdsts_afull = 1'b0;
    #2;
    checks++;
    if ({req_ack, req_err, PIM_AddrReq, rdsts_wren, busy, PIM_Addr, PIM_Size, rdsts_len, rdsts_nr} !== 50'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b err=%b areq=%b wren=%b busy=%b addr=%h size=%0d len=%0d nr=%0d, required all zero",
               req_ack, req_err, PIM_AddrReq, rdsts_wren, busy, PIM_Addr, PIM_Size, rdsts_len, rdsts_nr);
    end
    checks++;
    if ({PIM_RNW, PIM_RdModWr} !== 2'b10) begin
      errors++;
      $display("FAIL reset_constants: RNW=%b RdModWr=%b, required 1 0", PIM_RNW, PIM_RdModWr);
    end
    step();
    Rst = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_single();
    do_reset();
    set_port(2, 32'h0000_1000, 8);
    req_valid = 4'b0100;
    step();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({PIM_AddrReq, PIM_Addr, PIM_Size, busy} !== {1'b1, 32'h0000_1000, 4'd2, 1'b1}) begin
        errors++;
        $display("FAIL single_hold[%0d]: areq=%b addr=%h size=%0d busy=%b, required 1 00001000 2 1",
                 c, PIM_AddrReq, PIM_Addr, PIM_Size, busy);
      end
      if (c == 2) PIM_AddrAck = 1'b1;
      step();
    end
    PIM_AddrAck = 1'b0;
    checks++;
    if ({rdsts_wren, rdsts_len, rdsts_nr, req_ack, req_err, PIM_AddrReq} !== {1'b1, 6'd8, 3'd2, 4'b0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_done: wren=%b len=%0d nr=%0d ack=%b err=%b areq=%b, required 1 8 2 0100 0 0",
               rdsts_wren, rdsts_len, rdsts_nr, req_ack, req_err, PIM_AddrReq);
    end
    req_valid = '0;
    step();
    checks++;
    if ({rdsts_wren, req_ack, req_err, busy} !== 7'd0) begin
      errors++;
      $display("FAIL single_pulse_width: wren=%b ack=%b err=%b busy=%b, required all zero",
               rdsts_wren, req_ack, req_err, busy);
    end
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int last_t = 0;
    int exp_p;
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 32'(p * 256), 4);
    req_valid = 4'b1111;
    PIM_AddrAck = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      step();
      if (req_ack != '0) begin
        exp_p = rr_pick(model_last, req_valid);
        model_last = exp_p;
        checks++;
        if (req_ack !== 4'(4'd1 << exp_p) || rdsts_nr !== 3'(exp_p)) begin
          errors++;
          $display("FAIL rr_order[%0d]: ack=%b nr=%0d, required port %0d", grants, req_ack, rdsts_nr, exp_p);
        end
        if (grants > 0) begin
          checks++;
          if (t - last_t != 3) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: gap=%0d cycles, required 3", grants, t - last_t);
          end
        end
        grants++;
        last_t = t;
      end
    end
    checks++;
    if (grants != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d, required 5", grants);
    end
    req_valid = '0;
    PIM_AddrAck = 1'b0;
    step();
    step();
  endtask

  task automatic test_afull();
    do_reset();
    set_port(1, 32'hA0A0_0040, 16);
    rdsts_afull = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({PIM_AddrReq, busy, req_ack} !== 6'd0) begin
        errors++;
        $display("FAIL afull_block[%0d]: areq=%b busy=%b ack=%b, required 0 0 0000", c, PIM_AddrReq, busy, req_ack);
      end
    end
    rdsts_afull = 1'b0;
    step();
    checks++;
    if ({PIM_AddrReq, PIM_Addr, PIM_Size} !== {1'b1, 32'hA0A0_0040, 4'd3}) begin
      errors++;
      $display("FAIL afull_release: areq=%b addr=%h size=%0d, required 1 a0a00040 3", PIM_AddrReq, PIM_Addr, PIM_Size);
    end
    PIM_AddrAck = 1'b1;
    step();
    PIM_AddrAck = 1'b0;
    checks++;
    if ({rdsts_wren, rdsts_nr, rdsts_len, req_ack} !== {1'b1, 3'd1, 6'd16, 4'b0010}) begin
      errors++;
      $display("FAIL afull_done: wren=%b nr=%0d len=%0d ack=%b, required 1 1 16 0010", rdsts_wren, rdsts_nr, rdsts_len, req_ack);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reject();
    do_reset();
    set_port(0, 32'h0000_2000, 5);
    set_port(1, 32'h0000_3000, 1);
    req_valid = 4'b0011;
    step();
    checks++;
    if ({req_ack, req_err, PIM_AddrReq, rdsts_wren, busy} !== {4'b0001, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reject_pulse: ack=%b err=%b areq=%b wren=%b busy=%b, required 0001 1 0 0 1",
               req_ack, req_err, PIM_AddrReq, rdsts_wren, busy);
    end
    req_valid = 4'b0010;
    step();
    checks++;
    if ({req_ack, req_err, PIM_AddrReq, rdsts_wren, busy} !== 8'd0) begin
      errors++;
      $display("FAIL reject_idle: ack=%b err=%b areq=%b wren=%b busy=%b, required all zero",
               req_ack, req_err, PIM_AddrReq, rdsts_wren, busy);
    end
    step();
    checks++;
    if ({PIM_AddrReq, PIM_Addr, PIM_Size} !== {1'b1, 32'h0000_3000, 4'd0}) begin
      errors++;
      $display("FAIL reject_next: areq=%b addr=%h size=%0d, required 1 00003000 0", PIM_AddrReq, PIM_Addr, PIM_Size);
    end
    PIM_AddrAck = 1'b1;
    step();
    PIM_AddrAck = 1'b0;
    checks++;
    if ({rdsts_wren, rdsts_nr, rdsts_len, req_ack, req_err} !== {1'b1, 3'd1, 6'd1, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL reject_next_done: wren=%b nr=%0d len=%0d ack=%b err=%b, required 1 1 1 0010 0",
               rdsts_wren, rdsts_nr, rdsts_len, req_ack, req_err);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_reset_in_req();
    do_reset();
    set_port(3, 32'h0000_4000, 8);
    req_valid = 4'b1000;
    step();
    checks++;
    if (PIM_AddrReq !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_pre: areq=%b, required 1", PIM_AddrReq);
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({PIM_AddrReq, busy, rdsts_wren, req_ack} !== 7'd0) begin
      errors++;
      $display("FAIL rst_async_drop: areq=%b busy=%b wren=%b ack=%b, required all zero", PIM_AddrReq, busy, rdsts_wren, req_ack);
    end
    #1 Rst = 1'b0;
    set_port(0, 32'h0000_5000, 4);
    req_valid = 4'b1001;
    step();
    checks++;
    if ({PIM_AddrReq, PIM_Addr, rdsts_wren, req_ack} !== {1'b1, 32'h0000_5000, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL rst_port0_first: areq=%b addr=%h wren=%b ack=%b, required 1 00005000 0 0000",
               PIM_AddrReq, PIM_Addr, rdsts_wren, req_ack);
    end
    PIM_AddrAck = 1'b1;
    step();
    PIM_AddrAck = 1'b0;
    checks++;
    if ({rdsts_wren, rdsts_nr, req_ack} !== {1'b1, 3'd0, 4'b0001}) begin
      errors++;
      $display("FAIL rst_port0_done: wren=%b nr=%0d ack=%b, required 1 0 0001", rdsts_wren, rdsts_nr, req_ack);
    end
    req_valid = 4'b1000;
    step();
    step();
    checks++;
    if ({PIM_AddrReq, PIM_Addr} !== {1'b1, 32'h0000_4000}) begin
      errors++;
      $display("FAIL rst_port3_after: areq=%b addr=%h, required 1 00004000", PIM_AddrReq, PIM_Addr);
    end
    PIM_AddrAck = 1'b1;
    step();
    PIM_AddrAck = 1'b0;
    req_valid = '0;
    step();
  endtask

  task automatic test_spurious_ack();
    PIM_AddrAck = 1'b1;
    step();
    step();
    checks++;
    if ({PIM_AddrReq, busy, rdsts_wren, req_ack} !== 7'd0) begin
      errors++;
      $display("FAIL spurious_idle: areq=%b busy=%b wren=%b ack=%b, required all zero", PIM_AddrReq, busy, rdsts_wren, req_ack);
    end
    set_port(3, 32'hDEAD_BEE0, 32);
    req_valid = 4'b1000;
    step();
    PIM_AddrAck = 1'b0;
    checks++;
    if ({PIM_AddrReq, PIM_Addr, PIM_Size, rdsts_wren} !== {1'b1, 32'hDEAD_BEE0, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL spurious_grant: areq=%b addr=%h size=%0d wren=%b, required 1 deadbee0 4 0",
               PIM_AddrReq, PIM_Addr, PIM_Size, rdsts_wren);
    end
    step();
    checks++;
    if ({PIM_AddrReq, rdsts_wren} !== 2'b10) begin
      errors++;
      $display("FAIL spurious_still_waiting: areq=%b wren=%b, required 1 0", PIM_AddrReq, rdsts_wren);
    end
    PIM_AddrAck = 1'b1;
    step();
    PIM_AddrAck = 1'b0;
    checks++;
    if ({rdsts_wren, rdsts_len, rdsts_nr, req_ack} !== {1'b1, 6'd32, 3'd3, 4'b1000}) begin
      errors++;
      $display("FAIL spurious_done: wren=%b len=%0d nr=%0d ack=%b, required 1 32 3 1000", rdsts_wren, rdsts_len, rdsts_nr, req_ack);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] vmask = '0;
    logic [N-1:0] oh;
    int legal_lens [5] = '{1, 4, 8, 16, 32};
    int exp_p, sz, d, l;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < N; p++) begin
        if (((32'(vmask) >> p) & 32'd1) == 0 && $urandom_range(1, 0) == 1) begin
          l = ($urandom_range(4, 0) != 0) ? legal_lens[$urandom_range(4, 0)] : int'($urandom_range(63, 0));
          set_port(p, $urandom, l);
          vmask = vmask | N'(1 << p);
        end
      end
      if (vmask == '0) begin
        exp_p = int'($urandom_range(N - 1, 0));
        set_port(exp_p, $urandom, 8);
        vmask = N'(1 << exp_p);
      end
      req_valid = vmask;
      PIM_AddrAck = 1'($urandom_range(1, 0));
      exp_p = rr_pick(model_last, vmask);
      model_last = exp_p;
      sz = exp_size(port_len[exp_p]);
      d = int'($urandom_range(3, 0));
      oh = N'(1 << exp_p);
      step();
      PIM_AddrAck = 1'b0;
      if (sz >= 0) begin
        for (int c = 0; c <= d; c++) begin
          checks++;
          if ({PIM_AddrReq, PIM_Addr, PIM_Size, rdsts_wren, req_ack} !== {1'b1, port_addr[exp_p], 4'(sz), 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL rand_req[%0d.%0d]: areq=%b addr=%h size=%0d wren=%b ack=%b, required 1 %h %0d 0 0000",
                     it, c, PIM_AddrReq, PIM_Addr, PIM_Size, rdsts_wren, req_ack, port_addr[exp_p], sz);
          end
          if (c == d) PIM_AddrAck = 1'b1;
          step();
        end
        PIM_AddrAck = 1'b0;
        checks++;
        if ({rdsts_wren, rdsts_len, rdsts_nr, req_ack, req_err, PIM_AddrReq} !== {1'b1, 6'(port_len[exp_p]), 3'(exp_p), oh, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rand_done[%0d]: wren=%b len=%0d nr=%0d ack=%b err=%b areq=%b, required 1 %0d %0d %b 0 0",
                   it, rdsts_wren, rdsts_len, rdsts_nr, req_ack, req_err, PIM_AddrReq, port_len[exp_p], exp_p, oh);
        end
      end else begin
        checks++;
        if ({req_ack, req_err, PIM_AddrReq, rdsts_wren} !== {oh, 1'b1, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rand_reject[%0d]: ack=%b err=%b areq=%b wren=%b, required %b 1 0 0 (len %0d)",
                   it, req_ack, req_err, PIM_AddrReq, rdsts_wren, oh, port_len[exp_p]);
        end
      end
      vmask = vmask & ~oh;
      req_valid = vmask;
      step();
      checks++;
      if ({busy, rdsts_wren, req_ack} !== 6'd0) begin
        errors++;
        $display("FAIL rand_idle[%0d]: busy=%b wren=%b ack=%b, required all zero", it, busy, rdsts_wren, req_ack);
      end
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_afull();
    test_reject();
    test_reset_in_req();
    test_spurious_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
